// File: rtl/reg_cmd_engine_pkg.sv
// Shared types for the register-bus command engine: FSM state encoding and
// header-byte field positions.
package reg_cmd_pkg;

  localparam int HDR_FLAG = 7;
  localparam int HDR_RW   = 6;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [3:0] {
    IDLE,
    SIZE_L,
    SIZE_H,
    WR_DATA,
    WR_CSUM,
    RD_SETUP,
    RD_SAMPLE,
    RD_SEND,
    RD_CSUM
  } state_t;

endpackage

// File: rtl/reg_cmd_engine_if.sv
// Bridge byte streams plus the shared register bus driven by the command engine.
interface reg_cmd_engine_if;
  import reg_cmd_pkg::*;

  // rx: rx_valid is a one-cycle strobe with no back-pressure.
  // tx: a byte transfers on any cycle where tx_valid && tx_ready; once raised,
  // tx_valid and tx_data hold steady until that cycle.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] reg_address;
  logic [15:0]       reg_bytecnt;
  logic [7:0]        reg_datai;
  logic [7:0]        reg_datao;
  logic [15:0]       reg_size;
  logic              reg_read;
  logic              reg_write;
  logic              reg_addrvalid;
  logic [ADDR_W-1:0] reg_hypaddress;
  logic [15:0]       reg_hyplen;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_datao, reg_hyplen,
    output tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai, reg_size,
           reg_read, reg_write, reg_addrvalid, reg_hypaddress
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_datao, reg_hyplen,
    input  tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai, reg_size,
           reg_read, reg_write, reg_addrvalid, reg_hypaddress
  );

endinterface

// File: rtl/reg_cmd_timeout.sv
// Inter-byte idle counter: expires after TIMEOUT_CYCLES enabled cycles
// without a clear. A clear in the expiring cycle suppresses the expiry.
module reg_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/reg_cmd_engine.sv
// Host-side command engine: parses header/size/payload/checksum frames from the
// bridge, drives register-bus writes and read fetches, and returns read data.
module reg_cmd_engine
  import reg_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_i,
  reg_cmd_engine_if.master bus,
  output logic             busy,
  output logic             err_checksum,
  output logic             err_timeout,
  output logic             err_overrun,
  output state_t           state_dbg
);

  state_t            state, state_nxt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        size_lo_q;
  logic [15:0]       size_q;
  logic [15:0]       idx_q;
  logic [15:0]       rx_idx_q;
  logic [7:0]        csum_q;
  logic [7:0]        tx_byte_q;
  logic [7:0]        wr_data_q;
  logic              wr_q;
  logic              addrvalid_q;

  logic [15:0] size_full;
  logic [15:0] last_idx;
  logic        hdr_seen;
  logic        in_read;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expire;

  assign size_full = {bus.rx_data, size_lo_q};
  assign last_idx  = size_q - 16'd1;
  assign hdr_seen  = bus.rx_valid && bus.rx_data[HDR_FLAG];
  assign in_read   = state inside {RD_SETUP, RD_SAMPLE, RD_SEND, RD_CSUM};
  assign tmr_en    = state inside {SIZE_L, SIZE_H, WR_DATA, WR_CSUM};
  assign tmr_clr   = bus.rx_valid || (state == IDLE);

  reg_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timeout (
    .clk     (clk),
    .reset_i (reset_i),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expire  (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (hdr_seen) state_nxt = SIZE_L;
      SIZE_L:    if (bus.rx_valid) state_nxt = SIZE_H;
                 else if (tmr_expire) state_nxt = IDLE;
      SIZE_H: begin
        if (bus.rx_valid) begin
          if (!rw_q) begin
            state_nxt = (size_full == 16'd0) ? WR_CSUM : WR_DATA;
          end else if (size_full != 16'd0 || bus.reg_hyplen != 16'd0) begin
            state_nxt = RD_SETUP;
          end else begin
            state_nxt = RD_CSUM;
          end
        end else if (tmr_expire) begin
          state_nxt = IDLE;
        end
      end
      WR_DATA:   if (bus.rx_valid) begin
                   if (rx_idx_q == last_idx) state_nxt = WR_CSUM;
                 end else if (tmr_expire) begin
                   state_nxt = IDLE;
                 end
      WR_CSUM:   if (bus.rx_valid || tmr_expire) state_nxt = IDLE;
      RD_SETUP:  state_nxt = RD_SAMPLE;
      RD_SAMPLE: state_nxt = RD_SEND;
      RD_SEND:   if (bus.tx_ready) state_nxt = (idx_q == last_idx) ? RD_CSUM : RD_SETUP;
      RD_CSUM:   if (bus.tx_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.reg_read = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = tx_byte_q;
    busy         = (state != IDLE);
    state_dbg    = state;
    unique case (state)
      RD_SETUP, RD_SAMPLE: bus.reg_read = 1'b1;
      RD_SEND:             bus.tx_valid = 1'b1;
      RD_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rw_q         <= 1'b0;
      addr_q       <= '0;
      size_lo_q    <= '0;
      size_q       <= '0;
      idx_q        <= '0;
      rx_idx_q     <= '0;
      csum_q       <= '0;
      tx_byte_q    <= '0;
      wr_data_q    <= '0;
      wr_q         <= 1'b0;
      addrvalid_q  <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      wr_q         <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      // reg_bytecnt trails each write strobe so the strobe cycle shows its own index
      if (wr_q) idx_q <= idx_q + 16'd1;
      unique case (state)
        IDLE: if (hdr_seen) begin
          addr_q      <= bus.rx_data[ADDR_MSB:ADDR_LSB];
          rw_q        <= bus.rx_data[HDR_RW];
          addrvalid_q <= 1'b1;
          csum_q      <= bus.rx_data;
        end
        SIZE_L: if (bus.rx_valid) begin
          size_lo_q <= bus.rx_data;
          csum_q    <= csum_q + bus.rx_data;
        end
        SIZE_H: if (bus.rx_valid) begin
          csum_q   <= csum_q + bus.rx_data;
          idx_q    <= '0;
          rx_idx_q <= '0;
          size_q   <= (rw_q && size_full == 16'd0) ? bus.reg_hyplen : size_full;
        end
        WR_DATA: if (bus.rx_valid) begin
          csum_q    <= csum_q + bus.rx_data;
          wr_q      <= 1'b1;
          wr_data_q <= bus.rx_data;
          rx_idx_q  <= rx_idx_q + 16'd1;
        end
        WR_CSUM: if (bus.rx_valid) begin
          err_checksum <= (bus.rx_data != csum_q);
          addrvalid_q  <= 1'b0;
        end
        RD_SAMPLE: begin
          tx_byte_q <= bus.reg_datao;
          csum_q    <= csum_q + bus.reg_datao;
        end
        RD_SEND: if (bus.tx_ready && idx_q != last_idx) idx_q <= idx_q + 16'd1;
        RD_CSUM: if (bus.tx_ready) addrvalid_q <= 1'b0;
        default: ;
      endcase
      if (tmr_expire) begin
        err_timeout <= 1'b1;
        addrvalid_q <= 1'b0;
      end
      if (bus.rx_valid && in_read) err_overrun <= 1'b1;
    end
  end

  assign bus.reg_address    = addr_q;
  assign bus.reg_hypaddress = addr_q;
  assign bus.reg_bytecnt    = idx_q;
  assign bus.reg_datai      = wr_data_q;
  assign bus.reg_size       = size_q;
  assign bus.reg_write      = wr_q;
  assign bus.reg_addrvalid  = addrvalid_q;

endmodule

// File: tb/tb_reg_cmd_engine.sv
// Self-checking bench for reg_cmd_engine: directed frames from the test plan
// plus randomized frames scored against a frame-level reference model.
module tb_reg_cmd_engine;
  import reg_cmd_pkg::*;

  localparam int TMO = 16;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] c;
    logic [7:0]  d;
  } wr_t;

  logic   clk = 1'b0;
  logic   reset_i = 1'b1;
  logic   busy, err_checksum, err_timeout, err_overrun;
  state_t state_dbg;

  reg_cmd_engine_if bus ();

  reg_cmd_engine #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .bus          (bus),
    .busy         (busy),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register-block stand-in ----------------
  logic [15:0] hyp_len [64];

  function automatic logic [7:0] rd_val(input logic [5:0] a, input logic [15:0] i);
    int v;
    v = (int'(i) + 1) * 17 + ((a == 6'd5) ? 0 : int'(a) * 29);
    return v[7:0];
  endfunction

  assign bus.reg_hyplen = hyp_len[bus.reg_hypaddress];

  always @(posedge clk) begin
    if (bus.reg_read) bus.reg_datao <= rd_val(bus.reg_address, bus.reg_bytecnt);
  end

  // ---------------- tx_ready driver ----------------
  bit hold_low = 1'b0;
  bit tx_mode  = 1'b0;

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = hold_low ? 1'b0 : (tx_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- monitor ----------------
  wr_t        wr_obs[$];
  logic [7:0] tx_obs[$];
  int         tx_cyc[$];
  int cyc = 0, n_csum = 0, n_tmo = 0, n_ovr = 0, n_wr_noav = 0;
  int last_rx_cyc = 0, tmo_cyc = 0;
  logic av_at_tmo = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_i) begin
      if (bus.rx_valid) last_rx_cyc <= cyc;
      if (bus.reg_write) begin
        wr_obs.push_back(wr_t'({bus.reg_address, bus.reg_bytecnt, bus.reg_datai}));
        if (!bus.reg_addrvalid) n_wr_noav <= n_wr_noav + 1;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_obs.push_back(bus.tx_data);
        tx_cyc.push_back(cyc);
      end
      if (err_checksum) n_csum <= n_csum + 1;
      if (err_overrun) n_ovr <= n_ovr + 1;
      if (err_timeout) begin
        n_tmo     <= n_tmo + 1;
        tmo_cyc   <= cyc;
        av_at_tmo <= bus.reg_addrvalid;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  wr_t        exp_wr_q[$];
  int exp_csum = 0, exp_tmo = 0, exp_ovr = 0;
  int wr_ptr = 0, tx_ptr = 0;
  logic [7:0] frame_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: interpret one complete frame in frame_q.
  task automatic model_frame();
    logic [7:0] hdr, sum, v;
    int size, n;
    hdr  = frame_q[0];
    size = int'({frame_q[2], frame_q[1]});
    sum  = 8'(hdr + frame_q[1] + frame_q[2]);
    if (!hdr[6]) begin
      for (int i = 0; i < size; i++) begin
        exp_wr_q.push_back(wr_t'({hdr[5:0], 16'(i), frame_q[3 + i]}));
        sum = 8'(sum + frame_q[3 + i]);
      end
      if (frame_q[3 + size] != sum) exp_csum++;
    end else begin
      n = (size != 0) ? size : int'(hyp_len[hdr[5:0]]);
      for (int i = 0; i < n; i++) begin
        v = rd_val(hdr[5:0], 16'(i));
        exp_q.push_back(v);
        sum = 8'(sum + v);
      end
      exp_q.push_back(sum);
    end
  endtask

  task automatic score(input string tag);
    check({tag, ":wr_count"}, 32'(wr_obs.size() - wr_ptr), 32'(exp_wr_q.size()));
    while (exp_wr_q.size() > 0 && wr_ptr < wr_obs.size()) begin
      check({tag, ":wr"}, 32'(wr_obs[wr_ptr]), 32'(exp_wr_q[0]));
      wr_ptr++;
      void'(exp_wr_q.pop_front());
    end
    wr_ptr = wr_obs.size();
    exp_wr_q.delete();
    check({tag, ":tx_count"}, 32'(tx_obs.size() - tx_ptr), 32'(exp_q.size()));
    while (exp_q.size() > 0 && tx_ptr < tx_obs.size()) begin
      check({tag, ":tx"}, 32'(tx_obs[tx_ptr]), 32'(exp_q[0]));
      tx_ptr++;
      void'(exp_q.pop_front());
    end
    tx_ptr = tx_obs.size();
    exp_q.delete();
    check({tag, ":err_checksum"}, n_csum, exp_csum);
    check({tag, ":err_timeout"}, n_tmo, exp_tmo);
    check({tag, ":err_overrun"}, n_ovr, exp_ovr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int gap_max);
    foreach (frame_q[i]) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.rx_data  = frame_q[i];
      bus.rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic build_write(input logic [5:0] a, input int size, input bit bad);
    logic [7:0] s;
    frame_q.delete();
    frame_q.push_back({2'b10, a});
    frame_q.push_back(8'(size));
    frame_q.push_back(8'(size >> 8));
    for (int i = 0; i < size; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    s = 8'd0;
    foreach (frame_q[i]) s = 8'(s + frame_q[i]);
    frame_q.push_back(bad ? 8'(s + 8'd1) : s);
  endtask

  task automatic build_read(input logic [5:0] a, input int size);
    frame_q = '{{2'b11, a}, 8'(size), 8'(size >> 8)};
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":frame_done"}, 32'(busy), 32'd0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic drive_frame(input int gap_max, input string tag);
    model_frame();
    send_frame(gap_max);
    wait_idle(2000, tag);
    settle();
  endtask

  task automatic wait_tx_valid(input string tag);
    int n;
    n = 0;
    while (!bus.tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":tx_valid_seen"}, 32'(bus.tx_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d0;
    bit stable;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    foreach (hyp_len[i]) hyp_len[i] = 16'd0;
    hyp_len[5] = 16'd4;

    #2 reset_i = 1'b0;
    #1;
    check("rst:tx_valid", 32'(bus.tx_valid), 0);
    check("rst:reg_read", 32'(bus.reg_read), 0);
    check("rst:reg_write", 32'(bus.reg_write), 0);
    check("rst:reg_addrvalid", 32'(bus.reg_addrvalid), 0);
    check("rst:busy", 32'(busy), 0);
    check("rst:errs", 32'({err_checksum, err_timeout, err_overrun}), 0);
    check("rst:state", 32'(state_dbg), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);

    frame_q = '{8'h84, 8'h01, 8'h00, 8'hA5, 8'h2A};
    drive_frame(0, "echo");
    check("echo:wr_fields", 32'(wr_obs[wr_ptr]), 32'({6'd4, 16'd0, 8'hA5}));
    score("echo");

    frame_q = '{8'h90, 8'h04, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA8};
    drive_frame(0, "multi");
    score("multi");

    frame_q = '{8'hC5, 8'h00, 8'h00};
    drive_frame(0, "natread");
    check("natread:reg_size", 32'(bus.reg_size), 32'd4);
    check("natread:csum_byte", 32'(tx_obs[tx_ptr + 4]), 32'h6F);
    for (int i = 1; i < 4; i++)
      check("natread:byte_spacing", 32'(tx_cyc[tx_ptr + i] - tx_cyc[tx_ptr + i - 1]), 32'd3);
    score("natread");

    frame_q = '{8'h84, 8'h01, 8'h00, 8'hA5, 8'h2B};
    drive_frame(0, "badsum");
    check("badsum:state", 32'(state_dbg), 32'(IDLE));
    score("badsum");

    frame_q = '{8'h84, 8'h01};
    send_frame(0);
    exp_tmo++;
    wait_idle(200, "timeout");
    settle();
    check("timeout:latency", 32'(tmo_cyc - last_rx_cyc), 32'(TMO + 1));
    check("timeout:addrvalid", 32'(av_at_tmo), 32'd0);
    frame_q = '{8'h04};
    send_frame(0);
    settle();
    check("resync:busy", 32'(busy), 32'd0);
    frame_q = '{8'h84, 8'h01, 8'h00, 8'hA5, 8'h2A};
    drive_frame(0, "resync");
    score("resync");

    frame_q = '{8'h84, 8'h00, 8'h00, 8'h84};
    drive_frame(0, "zero_wr");
    score("zero_wr");

    frame_q = '{8'hC0, 8'h00, 8'h00};
    drive_frame(0, "zero_hyp");
    score("zero_hyp");

    frame_q = '{8'hC5, 8'h00, 8'h00};
    model_frame();
    send_frame(0);
    frame_q = '{8'h3C};
    send_frame(0);
    exp_ovr++;
    wait_idle(200, "overrun");
    settle();
    score("overrun");

    hold_low = 1'b1;
    frame_q = '{8'hC5, 8'h00, 8'h00};
    model_frame();
    send_frame(0);
    wait_tx_valid("bp");
    d0 = bus.tx_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data !== d0) stable = 1'b0;
    end
    check("bp:held_stable", 32'(stable), 32'd1);
    check("bp:first_byte", 32'(d0), 32'h11);
    hold_low = 1'b0;
    wait_idle(200, "bp");
    settle();
    score("bp");

    hold_low = 1'b1;
    frame_q = '{8'hC5, 8'h00, 8'h00};
    send_frame(0);
    wait_tx_valid("rst_mid");
    #2 reset_i = 1'b0;
    #1;
    check("rst_mid:tx_valid", 32'(bus.tx_valid), 0);
    check("rst_mid:reg_read", 32'(bus.reg_read), 0);
    check("rst_mid:reg_addrvalid", 32'(bus.reg_addrvalid), 0);
    check("rst_mid:busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset_i  = 1'b1;
    hold_low = 1'b0;
    settle();

    build_write(6'h2A, 258, 1'b0);
    drive_frame(0, "long_wr");
    score("long_wr");

    for (int k = 0; k < 40; k++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      tx_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        frame_q = '{8'($urandom_range(0, 127))};
        send_frame(0);
      end
      if ($urandom_range(0, 1) == 1) begin
        build_write(a, $urandom_range(0, 6), $urandom_range(0, 3) == 0);
      end else begin
        hyp_len[a] = 16'($urandom_range(0, 5));
        build_read(a, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 5));
      end
      drive_frame($urandom_range(0, 3), "rnd");
      score("rnd");
    end

    check("addrvalid_during_write", n_wr_noav, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_cmd_engine.md
Name: reg_cmd_engine

Overview:
- Host-side protocol engine for the OpenADC register bus. It drives the bus that all register blocks respond to.
- Parses the serial command byte stream (header, size LSB, size MSB, payload, checksum) arriving from the USB/serial bridge.
- Generates register-bus strobes for writes and fetches register bytes for reads.
- Serialises read data plus checksum back to the bridge.

Parameters:
- TIMEOUT_CYCLES, 1000000, inter-byte idle cycles tolerated mid-frame before abort.
- TMR_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte from bridge
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to bridge
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  bridge accepts byte when tx_valid&tx_ready
- reg_address  out  6  register address (header A5..A0)
- reg_bytecnt  out  16  current byte index within payload
- reg_datai  out  8  write data
- reg_datao  in  8  read data from register blocks (shared bus)
- reg_size  out  16  effective transfer size
- reg_read  out  1  read fetch strobe
- reg_write  out  1  one-cycle write strobe
- reg_addrvalid  out  1  high from header accept until frame end
- reg_hypaddress  out  6  address for natural-length lookup
- reg_hyplen  in  16  natural length of reg_hypaddress
- busy  out  1  high when state != IDLE
- err_checksum  out  1  one-cycle pulse, write checksum mismatch
- err_timeout  out  1  one-cycle pulse, frame aborted by timeout
- err_overrun  out  1  one-cycle pulse, rx byte arrived during read phase

Behaviour:
- Reset (reset_i low, async):
  - state IDLE; all outputs 0, including tx_valid, reg_read, reg_write, reg_addrvalid and all error pulses.
  - Takes effect immediately mid-frame; in-flight tx byte is dropped.
- Header format: bit7=1 marks a header; bit6 RW (1=read, 0=write); bits5:0 address.
  - In IDLE, bytes with bit7=0 are discarded (resync).
- Checksum: modulo-256 sum of header, size LSB, size MSB and every payload byte. Accumulator is cleared on header accept.
- States:
  - IDLE: on header, latch address into reg_address and reg_hypaddress, latch RW, assert reg_addrvalid, go to SIZE_L.
  - SIZE_L: next byte gives size[7:0]. Go to SIZE_H.
  - SIZE_H: next byte gives size[15:8]; clear reg_bytecnt. Then:
    - write, size>0: WR_DATA.
    - write, size=0: WR_CSUM.
    - read, size>0: reg_size=size, go to RD_SETUP.
    - read, size=0: reg_size=reg_hyplen sampled this cycle. If reg_hyplen=0, go to RD_CSUM; else RD_SETUP.
  - WR_DATA: each rx byte produces:
    - next cycle: reg_write=1 for exactly one cycle, with reg_datai=byte and reg_bytecnt=index;
    - the cycle after: reg_bytecnt increments.
    - Back-to-back rx_valid is supported.
    - After byte size-1, go to WR_CSUM.
  - WR_CSUM: compare the received byte to the accumulator.
    - Mismatch: pulse err_checksum.
    - Committed writes are not undone.
    - Go to IDLE and deassert reg_addrvalid.
  - RD_SETUP: reg_read=1, reg_bytecnt=index, for one cycle. Covers the register block's one-cycle registered valid.
  - RD_SAMPLE: reg_read=1; capture reg_datao into tx_data, add it to the accumulator, go to RD_SEND.
  - RD_SEND: tx_valid=1 until tx_ready.
    - On accept: if index=reg_size-1, go to RD_CSUM; else increment index and go to RD_SETUP.
  - RD_CSUM: tx_data=accumulator, tx_valid=1 until accepted. Then IDLE, reg_addrvalid=0.
- Read throughput: minimum 3 cycles/byte with tx_ready tied high.
- Timeout: counter clears on every rx_valid and in IDLE, and increments in SIZE_L, SIZE_H, WR_DATA and WR_CSUM. When it reaches TIMEOUT_CYCLES: pulse err_timeout, go to IDLE, deassert reg_addrvalid.
  - Read states are not timed; they are paced by tx_ready.
- rx_valid during RD_* states: byte dropped, err_overrun pulses.
- rx_valid in the same cycle as a timeout: the byte wins and the counter clears.
- Index compares use full 16 bits; size 0xFFFF is legal, no wrap.

Decomposition:
- Package reg_cmd_pkg holds:
  - state enum (IDLE, SIZE_L, SIZE_H, WR_DATA, WR_CSUM, RD_SETUP, RD_SAMPLE, RD_SEND, RD_CSUM);
  - header field constants: HDR_FLAG bit 7, HDR_RW bit 6, address bits 5:0.
- One sub-module: reg_cmd_timeout. Inter-byte counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write echo: rx 84 01 00 A5 2A -> one reg_write with reg_address=4, reg_bytecnt=0, reg_datai=A5; no error pulses; busy drops after checksum.
- Multi-byte write: rx 90 04 00 78 56 34 12 A8 -> four reg_write pulses, bytecnt 0..3 with data 78,56,34,12; no err_checksum.
- Natural read: rx C5 00 00 with reg_hyplen=4 and model returning 11,22,33,44 -> reg_size=4; tx 11 22 33 44 6F.
- Bad checksum: rx 84 01 00 A5 2B -> reg_write still occurs once; err_checksum pulses one cycle; state IDLE.
- Timeout/resync: TIMEOUT_CYCLES=16; rx 84 01 then silence -> err_timeout on the 16th idle cycle and reg_addrvalid=0. Following byte 04 is ignored; next 84 01 00 A5 2A is accepted normally.
- Backpressure/reset: read C5 00 00 with tx_ready low 10 cycles -> tx_valid and tx_data stable throughout. Assert reset_i low mid-read -> tx_valid, reg_read, reg_addrvalid and busy all 0 immediately, without waiting for a clk edge.
